muldiv_iter: RTL and testbench
==============================

Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the EXE stage. Replaces the separate fixed-latency mult-stall and div start/ready logic with one engine.
- Accepts MULT/MULTU/DIV/DIVU operands and produces {hi, lo} after a known latency.
- Holds the result until EXE consumes it. Can be cancelled by pipeline flush or exception.

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits.
- MUL_CYCLES, 4, multiply iteration cycles; WIDTH/MUL_CYCLES bits retired per cycle; must divide WIDTH evenly, range 1..WIDTH.
- DIV_EARLY_OUT, 1, when 1 a divide by a divisor of 0 or 1 skips CALC.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  request a new operation; sampled only in IDLE.
- op_i  in  2  operation: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV; sampled with start_i.
- a_i  in  WIDTH  multiplicand / dividend.
- b_i  in  WIDTH  multiplier / divisor.
- cancel_i  in  1  abort (EX flush or MEM exception).
- ack_i  in  1  consumer has taken the result.
- busy_o  out  1  high in CALC and FIX.
- valid_o  out  1  high in DONE.
- hi_o  out  WIDTH  product high half / remainder.
- lo_o  out  WIDTH  product low half / quotient.

Behaviour:
- States: IDLE, CALC, FIX, DONE; encoding is 2 bits.
- Reset: state IDLE, iteration counter 0, busy_o=0, valid_o=0, hi_o=0, lo_o=0.

Transitions:
- IDLE & start_i & !cancel_i -> CALC. Latch op, the operand magnitudes and the sign flags. Sign flags are used only for MULT/DIV; the magnitude of the most-negative value is 2^(WIDTH-1), held unsigned.
- CALC, multiply: shift-add WIDTH/MUL_CYCLES bits per cycle for MUL_CYCLES cycles, then -> FIX.
- CALC, divide: restoring division, 1 quotient bit per cycle for WIDTH cycles, then -> FIX.
- DIV_EARLY_OUT=1 and divisor magnitude 0 or 1: IDLE -> FIX directly.
- FIX: apply signs, load hi_o/lo_o, -> DONE.
  - Product is negated if signs differ.
  - Quotient is negated if signs differ.
  - Remainder takes the sign of the dividend.
- DONE: valid_o=1; hi_o/lo_o stable. On ack_i -> IDLE, or -> CALC if start_i is also high that cycle (back-to-back; new operands latched).
- cancel_i in any state -> IDLE next cycle; valid_o and busy_o low next cycle; hi_o/lo_o keep their old values. cancel_i beats start_i and ack_i in the same cycle.
- start_i outside IDLE/DONE-with-ack is ignored, with no side effect.

Latency (start cycle to first valid_o cycle):
- Multiply: MUL_CYCLES+2.
- Divide: WIDTH+2.
- Early-out divide: 2.

Arithmetic rules:
- Multiply: full 2*WIDTH product, hi = upper half.
- Divide by zero: lo = all ones, hi = a_i unchanged (both signed and unsigned).
- Divide by one: lo = a_i, hi = 0.
- DIV of -2^(WIDTH-1) by -1: lo = -2^(WIDTH-1) (wrap), hi = 0; no trap.

Timing and reset:
- All datapath registers are updated only on clk; no combinational path from a_i/b_i to outputs.
- rst mid-operation: same as reset, and the result is lost.

Decomposition:
- Shared package muldiv_pkg: op encodings (MULTU/MULT/DIVU/DIV), state encoding, and the helper function for conditional two's-complement negate of width N.
- Sub-module muldiv_div_step: one combinational restoring-division step (partial remainder, divisor in; next remainder, quotient bit out). It is instantiated once and iterated by the state machine.
- The multiply step stays inline.

Test Plan:
- WIDTH=32, MUL_CYCLES=4; MULT a=0xFFFFFFFD (-3), b=5 -> valid_o at cycle 6; hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100/7 -> valid_o at cycle 34, lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 with DIV_EARLY_OUT=1 -> valid_o at cycle 2, lo=0xFFFFFFFF, hi=0x1234. With DIV_EARLY_OUT=0 -> same values at cycle 34.
- DIVU started, cancel_i pulsed at CALC cycle 10 -> busy_o low next cycle, valid_o never rises. A new start 1 cycle later produces the correct result. cancel_i+start_i together in IDLE -> no operation starts.
- Result held with ack_i low for 20 cycles -> valid_o, hi_o, lo_o stable; start_i in that window is ignored. ack_i+start_i in the same cycle -> second op completes at the expected latency.
- rst asserted mid-CALC -> next cycle all outputs 0, state IDLE. Repeat the MULT check with MUL_CYCLES=1 (latency 3) and MUL_CYCLES=32 (latency 34) -> same products.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide engine: op and state
// encodings plus the conditional two's-complement helper.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OpMultu = 2'd0,
      OpMult  = 2'd1,
      OpDivu  = 2'd2,
      OpDiv   = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StFix  = 2'd2,
      StDone = 2'd3
   } state_e;

   // Callers zero-extend an N-bit value to NegMaxW and keep the low N bits.
   localparam int unsigned NegMaxW = 128;

   function automatic logic [NegMaxW-1:0] cond_neg(input logic [NegMaxW-1:0] v,
                                                   input logic               neg);
      return neg ? (~v + NegMaxW'(1)) : v;
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract the
// divisor when it fits.
module muldiv_div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_q
);
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;

   always_comb begin
      w_shift = {i_rem, i_bit};
      // When the divisor fits, the true difference is below 2^WIDTH.
      w_diff  = w_shift[WIDTH-1:0] - i_div;
      o_q     = (w_shift >= {1'b0, i_div});
      o_rem   = o_q ? w_diff : w_shift[WIDTH-1:0];
   end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU engine: shift-add multiply, restoring divide,
// one sign fix-up cycle, result held until acknowledged or cancelled.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned MUL_CYCLES    = 4,
   parameter bit          DIV_EARLY_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cancel_i,
   input  logic             ack_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   localparam int unsigned K    = WIDTH / MUL_CYCLES;
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   state_e            r_state, w_state_next;
   op_e               r_op;
   logic [WIDTH-1:0]  r_opnd, r_hi, r_lo, r_res_hi, r_res_lo;
   logic              r_neg_a, r_neg_b, r_b_zero;
   logic [CntW-1:0]   r_cnt;

   logic              w_load, w_in_div, w_neg_a, w_neg_b, w_early, w_calc_div, w_last;
   logic [WIDTH-1:0]  w_mag_a, w_mag_b, w_div_rem;
   logic              w_div_q;
   logic [WIDTH+K-1:0] w_pp, w_sum;
   logic [2*WIDTH-1:0] w_mul_next, w_prod_fix;
   logic [WIDTH-1:0]  w_quo_fix, w_rem_fix;

   // Operand capture: magnitudes are unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
   always_comb begin
      w_in_div = op_i[1];
      w_neg_a  = op_i[0] & a_i[WIDTH-1];
      w_neg_b  = op_i[0] & b_i[WIDTH-1];
      w_mag_a  = w_neg_a ? (~a_i + 1'b1) : a_i;
      w_mag_b  = w_neg_b ? (~b_i + 1'b1) : b_i;
      w_early  = DIV_EARLY_OUT && w_in_div && (w_mag_b <= WIDTH'(1));
   end

   always_comb begin
      w_calc_div = (r_op == OpDivu) || (r_op == OpDiv);
      w_last     = w_calc_div ? (r_cnt == CntW'(WIDTH - 1)) : (r_cnt == CntW'(MUL_CYCLES - 1));
      w_pp       = {{K{1'b0}}, r_opnd} * {{WIDTH{1'b0}}, r_lo[K-1:0]};
      w_sum      = {{K{1'b0}}, r_hi} + w_pp;
      w_mul_next = (2 * WIDTH)'({w_sum, r_lo} >> K);
      w_prod_fix = (2 * WIDTH)'(cond_neg(NegMaxW'({r_hi, r_lo}), r_neg_a ^ r_neg_b));
      w_quo_fix  = r_b_zero ? '1 : WIDTH'(cond_neg(NegMaxW'(r_lo), r_neg_a ^ r_neg_b));
      w_rem_fix  = WIDTH'(cond_neg(NegMaxW'(r_hi), r_neg_a));
   end

   muldiv_div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .i_rem (r_hi),
      .i_bit (r_lo[WIDTH-1]),
      .i_div (r_opnd),
      .o_rem (w_div_rem),
      .o_q   (w_div_q)
   );

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      case (r_state)
         StIdle:  w_load = start_i;
         StCalc:  if (w_last) w_state_next = StFix;
         StFix:   w_state_next = StDone;
         StDone: begin
            if (ack_i) begin
               w_state_next = StIdle;
               w_load       = start_i;
            end
         end
         default: w_state_next = StIdle;
      endcase
      if (w_load) w_state_next = w_early ? StFix : StCalc;
      if (cancel_i) begin
         w_state_next = StIdle;
         w_load       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= StIdle;
         r_op     <= OpMultu;
         r_cnt    <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
         r_b_zero <= 1'b0;
         r_res_hi <= '0;
         r_res_lo <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_load) begin
            r_op     <= op_e'(op_i);
            r_cnt    <= '0;
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_b_zero <= w_in_div && (w_mag_b == '0);
            r_opnd   <= w_in_div ? w_mag_b : w_mag_a;
            // Early-out by zero preloads the restoring-division outcome directly.
            if (w_early && (w_mag_b == '0)) begin
               r_hi <= w_mag_a;
               r_lo <= '1;
            end else begin
               r_hi <= '0;
               r_lo <= w_in_div ? w_mag_a : w_mag_b;
            end
         end else if (cancel_i) begin
            r_cnt <= '0;
         end else if (r_state == StCalc) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_calc_div) begin
               r_hi <= w_div_rem;
               r_lo <= {r_lo[WIDTH-2:0], w_div_q};
            end else begin
               {r_hi, r_lo} <= w_mul_next;
            end
         end else if (r_state == StFix) begin
            if (w_calc_div) begin
               r_res_hi <= w_rem_fix;
               r_res_lo <= w_quo_fix;
            end else begin
               {r_res_hi, r_res_lo} <= w_prod_fix;
            end
         end
      end
   end

   assign busy_o  = (r_state == StCalc) || (r_state == StFix);
   assign valid_o = (r_state == StDone);
   assign hi_o    = r_res_hi;
   assign lo_o    = r_res_lo;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: four instances share stimulus (default,
// no early-out, MUL_CYCLES=1, MUL_CYCLES=32); each task checks one scenario.
module tb_muldiv_iter;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, cancel, ack;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy [4];
   logic        valid [4];
   logic [31:0] hi [4];
   logic [31:0] lo [4];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   muldiv_iter #(.WIDTH(32), .MUL_CYCLES(4), .DIV_EARLY_OUT(1'b1)) dut (
      .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
      .cancel_i(cancel), .ack_i(ack), .busy_o(busy[0]), .valid_o(valid[0]),
      .hi_o(hi[0]), .lo_o(lo[0]));
   muldiv_iter #(.WIDTH(32), .MUL_CYCLES(4), .DIV_EARLY_OUT(1'b0)) dut_ne (
      .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
      .cancel_i(cancel), .ack_i(ack), .busy_o(busy[1]), .valid_o(valid[1]),
      .hi_o(hi[1]), .lo_o(lo[1]));
   muldiv_iter #(.WIDTH(32), .MUL_CYCLES(1), .DIV_EARLY_OUT(1'b1)) dut_m1 (
      .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
      .cancel_i(cancel), .ack_i(ack), .busy_o(busy[2]), .valid_o(valid[2]),
      .hi_o(hi[2]), .lo_o(lo[2]));
   muldiv_iter #(.WIDTH(32), .MUL_CYCLES(32), .DIV_EARLY_OUT(1'b1)) dut_m32 (
      .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
      .cancel_i(cancel), .ack_i(ack), .busy_o(busy[3]), .valid_o(valid[3]),
      .hi_o(hi[3]), .lo_o(lo[3]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; cancel = 1'b0; ack = 1'b0;
      op = 2'd0; a = '0; b = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // t0 is the start cycle; the cycle after the sampling edge is cycle 1.
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int t0);
      op = o; a = x; b = y; start = 1'b1;
      t0 = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input int idx, input int t0, output int lat);
      int n = 0;
      while (!valid[idx] && n < 100) begin
         tick();
         n++;
      end
      lat = valid[idx] ? cyc - t0 : -1;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy[0]); end
      checks++; if (valid[0] !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid[0]); end
      checks++; if (hi[0] !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi[0]); end
      checks++; if (lo[0] !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo[0]); end
   endtask

   task automatic test_mult();
      int t0, lat;
      do_reset();
      issue(OpMult, 32'hFFFF_FFFD, 32'd5, t0);
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL mult_busy got %b want 1", busy[0]); end
      wait_valid(0, t0, lat);
      checks++; if (lat != 6) begin errors++; $display("FAIL mult_lat got %0d want 6", lat); end
      checks++; if (hi[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi[0]); end
      checks++; if (lo[0] !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h want fffffff1", lo[0]); end
      do_ack();
      checks++; if (valid[0] !== 1'b0) begin errors++; $display("FAIL mult_ack_valid got %b want 0", valid[0]); end
      issue(OpMult, 32'h8000_0000, 32'h8000_0000, t0);
      wait_valid(0, t0, lat);
      checks++; if (lat != 6) begin errors++; $display("FAIL mult2_lat got %0d want 6", lat); end
      checks++; if (hi[0] !== 32'h4000_0000) begin errors++; $display("FAIL mult2_hi got %h want 40000000", hi[0]); end
      checks++; if (lo[0] !== 32'h0) begin errors++; $display("FAIL mult2_lo got %h want 0", lo[0]); end
      do_ack();
      issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0);
      wait_valid(0, t0, lat);
      checks++; if (hi[0] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi[0]); end
      checks++; if (lo[0] !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo[0]); end
      do_ack();
   endtask

   task automatic test_div();
      int t0, lat;
      do_reset();
      issue(OpDivu, 32'd100, 32'd7, t0);
      wait_valid(0, t0, lat);
      checks++; if (lat != 34) begin errors++; $display("FAIL divu_lat got %0d want 34", lat); end
      checks++; if (lo[0] !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want 0000000e", lo[0]); end
      checks++; if (hi[0] !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want 00000002", hi[0]); end
      do_ack();
      issue(OpDiv, 32'hFFFF_FFF9, 32'd2, t0);
      wait_valid(0, t0, lat);
      checks++; if (lo[0] !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got %h want fffffffd", lo[0]); end
      checks++; if (hi[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got %h want ffffffff", hi[0]); end
      do_ack();
      issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, t0);
      wait_valid(0, t0, lat);
      checks++; if (lat != 2) begin errors++; $display("FAIL div_wrap_lat got %0d want 2", lat); end
      checks++; if (lo[0] !== 32'h8000_0000) begin errors++; $display("FAIL div_wrap_lo got %h want 80000000", lo[0]); end
      checks++; if (hi[0] !== 32'h0) begin errors++; $display("FAIL div_wrap_hi got %h want 0", hi[0]); end
      do_ack();
      issue(OpDiv, 32'hFFFF_FFFB, 32'd0, t0);
      wait_valid(0, t0, lat);
      checks++; if (lo[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_zero_s_lo got %h want ffffffff", lo[0]); end
      checks++; if (hi[0] !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div_zero_s_hi got %h want fffffffb", hi[0]); end
      do_ack();
   endtask

   task automatic test_div_zero();
      int t0, lat;
      do_reset();
      issue(OpDivu, 32'h1234, 32'd0, t0);
      wait_valid(0, t0, lat);
      checks++; if (lat != 2) begin errors++; $display("FAIL dz_early_lat got %0d want 2", lat); end
      checks++; if (lo[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_early_lo got %h want ffffffff", lo[0]); end
      checks++; if (hi[0] !== 32'h1234) begin errors++; $display("FAIL dz_early_hi got %h want 00001234", hi[0]); end
      wait_valid(1, t0, lat);
      checks++; if (lat != 34) begin errors++; $display("FAIL dz_full_lat got %0d want 34", lat); end
      checks++; if (lo[1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_full_lo got %h want ffffffff", lo[1]); end
      checks++; if (hi[1] !== 32'h1234) begin errors++; $display("FAIL dz_full_hi got %h want 00001234", hi[1]); end
   endtask

   task automatic test_cancel();
      int  t0, lat;
      logic seen;
      do_reset();
      issue(OpMultu, 32'd6, 32'd7, t0);
      wait_valid(0, t0, lat);
      do_ack();
      issue(OpDivu, 32'd100, 32'd7, t0);
      while (cyc - t0 < 10) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b want 0", busy[0]); end
      checks++; if (lo[0] !== 32'd42) begin errors++; $display("FAIL cancel_lo_kept got %h want 0000002a", lo[0]); end
      seen = valid[0];
      tick();
      seen = seen | valid[0];
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL cancel_no_valid got %b want 0", seen); end
      issue(OpDivu, 32'd100, 32'd7, t0);
      wait_valid(0, t0, lat);
      checks++; if (lat != 34) begin errors++; $display("FAIL restart_lat got %0d want 34", lat); end
      checks++; if (lo[0] !== 32'd14) begin errors++; $display("FAIL restart_lo got %h want 0000000e", lo[0]); end
      checks++; if (hi[0] !== 32'd2) begin errors++; $display("FAIL restart_hi got %h want 00000002", hi[0]); end
      do_ack();
      cancel = 1'b1;
      issue(OpDivu, 32'd9, 32'd3, t0);
      cancel = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         seen = seen | busy[0] | valid[0];
         tick();
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL cancel_start_idle got %b want 0", seen); end
      checks++; if (lo[0] !== 32'd14) begin errors++; $display("FAIL cancel_start_lo got %h want 0000000e", lo[0]); end
   endtask

   task automatic test_back_to_back();
      int  t0, lat;
      logic ok;
      do_reset();
      issue(OpMultu, 32'd6, 32'd7, t0);
      wait_valid(0, t0, lat);
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         start = (i >= 5 && i < 10);
         op = OpMultu; a = 32'd3; b = 32'd3;
         if (!(valid[0] === 1'b1 && busy[0] === 1'b0 && hi[0] === 32'd0 && lo[0] === 32'd42))
            ok = 1'b0;
         tick();
      end
      start = 1'b0;
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hold_stable got %b want 1", ok); end
      checks++; if (lo[0] !== 32'd42) begin errors++; $display("FAIL hold_lo got %h want 0000002a", lo[0]); end
      ack = 1'b1;
      issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0);
      ack = 1'b0;
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy[0]); end
      wait_valid(0, t0, lat);
      checks++; if (lat != 6) begin errors++; $display("FAIL b2b_lat got %0d want 6", lat); end
      checks++; if (hi[0] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_hi got %h want fffffffe", hi[0]); end
      checks++; if (lo[0] !== 32'h0000_0001) begin errors++; $display("FAIL b2b_lo got %h want 00000001", lo[0]); end
      do_ack();
   endtask

   task automatic test_reset_mid();
      int t0, lat;
      do_reset();
      issue(OpMultu, 32'd6, 32'd7, t0);
      wait_valid(0, t0, lat);
      do_ack();
      issue(OpDivu, 32'd100, 32'd7, t0);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy[0]); end
      checks++; if (valid[0] !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", valid[0]); end
      checks++; if (lo[0] !== 32'h0) begin errors++; $display("FAIL rstmid_lo got %h want 0", lo[0]); end
      repeat (3) tick();
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b want 0", busy[0]); end
   endtask

   task automatic test_mul_cycles();
      int t0, lat;
      do_reset();
      issue(OpMult, 32'hFFFF_FFFD, 32'd5, t0);
      wait_valid(2, t0, lat);
      checks++; if (lat != 3) begin errors++; $display("FAIL m1_lat got %0d want 3", lat); end
      checks++; if ({hi[2], lo[2]} !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL m1_prod got %h want fffffffffffffff1", {hi[2], lo[2]}); end
      wait_valid(3, t0, lat);
      checks++; if (lat != 34) begin errors++; $display("FAIL m32_lat got %0d want 34", lat); end
      checks++; if ({hi[3], lo[3]} !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL m32_prod got %h want fffffffffffffff1", {hi[3], lo[3]}); end
      do_reset();
      issue(OpMult, 32'h8000_0000, 32'h8000_0000, t0);
      wait_valid(2, t0, lat);
      checks++; if ({hi[2], lo[2]} !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL m1_prod2 got %h want 4000000000000000", {hi[2], lo[2]}); end
      wait_valid(3, t0, lat);
      checks++; if ({hi[3], lo[3]} !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL m32_prod2 got %h want 4000000000000000", {hi[3], lo[3]}); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_cancel();
      test_back_to_back();
      test_reset_mid();
      test_mul_cycles();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
